// File: rtl/dff_response_checker.sv
// On-chip response checker for a D flip-flop under test: compares q against d delayed by LAT
// clocks and qb against ~q, accumulating check/error counts over a WINDOW-cycle run.
module dff_response_checker #(
   parameter int LAT    = 1,
   parameter int WINDOW = 16,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             d,
   input  logic             q,
   input  logic             qb,
   output logic             busy,
   output logic             done,
   output logic             err_flag,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] chk_cnt,
   output logic [CNT_W-1:0] first_err_idx
);

   // state   | meaning
   // S_IDLE  | no run since reset
   // S_WARMUP| history filling for LAT cycles, no checks
   // S_CHECK | one check per cycle until WINDOW checks are done
   // S_DONE  | results frozen until the next start
   typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_CHECK, S_DONE} state_t;

   localparam int               WARM_W    = 4;
   localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(LAT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(WINDOW - 1);

   state_t            state_q, state_d;
   logic [WARM_W-1:0] warm_q, warm_d;
   logic [LAT-1:0]    hist_q, hist_d;
   logic              err_flag_q, err_flag_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]  chk_cnt_q, chk_cnt_d;
   logic [CNT_W-1:0]  first_q, first_d;
   logic              d_ref;
   logic              fail;

   // Oldest history slot holds d as sampled LAT edges ago.
   assign d_ref = hist_q[LAT-1];
   assign fail  = (q != d_ref) || (qb == q);

   always_comb begin
      hist_d    = hist_q;
      hist_d[0] = d;
      for (int i = 1; i < LAT; i++) begin
         hist_d[i] = hist_q[i-1];
      end
   end

   always_comb begin
      state_d    = state_q;
      warm_d     = warm_q;
      err_flag_d = err_flag_q;
      err_cnt_d  = err_cnt_q;
      chk_cnt_d  = chk_cnt_q;
      first_d    = first_q;
      if (start) begin
         // Restart beats any check landing on the same edge, including the final one.
         state_d    = S_WARMUP;
         warm_d     = WARM_LOAD;
         err_flag_d = 1'b0;
         err_cnt_d  = '0;
         chk_cnt_d  = '0;
         first_d    = CNT_MAX;
      end else begin
         case (state_q)
            S_WARMUP: begin
               if (warm_q == '0) begin
                  state_d = S_CHECK;
               end else begin
                  warm_d = warm_q - WARM_W'(1);
               end
            end
            S_CHECK: begin
               chk_cnt_d = chk_cnt_q + CNT_W'(1);
               if (fail) begin
                  err_flag_d = 1'b1;
                  if (!err_flag_q) begin
                     first_d = chk_cnt_q;
                  end
                  if (err_cnt_q != CNT_MAX) begin
                     err_cnt_d = err_cnt_q + CNT_W'(1);
                  end
               end
               if (chk_cnt_q == LAST_IDX) begin
                  state_d = S_DONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         warm_q     <= '0;
         hist_q     <= '0;
         err_flag_q <= 1'b0;
         err_cnt_q  <= '0;
         chk_cnt_q  <= '0;
         first_q    <= CNT_MAX;
      end else begin
         state_q    <= state_d;
         warm_q     <= warm_d;
         hist_q     <= hist_d;
         err_flag_q <= err_flag_d;
         err_cnt_q  <= err_cnt_d;
         chk_cnt_q  <= chk_cnt_d;
         first_q    <= first_d;
      end
   end

   assign busy          = (state_q == S_WARMUP) || (state_q == S_CHECK);
   assign done          = (state_q == S_DONE);
   assign err_flag      = err_flag_q;
   assign err_cnt       = err_cnt_q;
   assign chk_cnt       = chk_cnt_q;
   assign first_err_idx = first_q;

endmodule

// File: tb/tb_dff_response_checker.sv
// Bench for dff_response_checker: two instances (LAT=1/WINDOW=16/CNT_W=8 and LAT=2/WINDOW=3/CNT_W=2)
// driven by a virtual flip-flop with selectable faults, scored against a run-timeline model.
module tb_dff_response_checker;
   localparam int L0 = 1, W0 = 16, C0 = 8;
   localparam int L1 = 2, W1 = 3,  C1 = 2;

   logic clk = 1'b0, rst = 1'b0, start = 1'b0, d = 1'b0;
   logic q0 = 1'b0, qb0 = 1'b1, q1 = 1'b0, qb1 = 1'b1;
   logic busy0, done0, ef0, busy1, done1, ef1;
   logic [C0-1:0] ec0, cc0, fe0;
   logic [C1-1:0] ec1, cc1, fe1;

   always #5 clk = ~clk;

   dff_response_checker #(.LAT(L0), .WINDOW(W0), .CNT_W(C0)) u_big (
      .clk(clk), .rst(rst), .start(start), .d(d), .q(q0), .qb(qb0),
      .busy(busy0), .done(done0), .err_flag(ef0), .err_cnt(ec0), .chk_cnt(cc0),
      .first_err_idx(fe0));

   dff_response_checker #(.LAT(L1), .WINDOW(W1), .CNT_W(C1)) u_small (
      .clk(clk), .rst(rst), .start(start), .d(d), .q(q1), .qb(qb1),
      .busy(busy1), .done(done1), .err_flag(ef1), .err_cnt(ec1), .chk_cnt(cc1),
      .first_err_idx(fe1));

   int n_cmp = 0, n_fail = 0;
   int edge_n = 0, r_edge = 0;
   logic dh [0:8191];
   int latm [2] = '{L0, L1};
   int winm [2] = '{W0, W1};
   int maxm [2] = '{255, 3};
   // fault modes: 0 ideal, 1 q stuck-0, 2 qb tied to q, 3 q flipped at check inj, 4 random, 5 all wrong
   int mode [2] = '{0, 0};
   int inj  [2] = '{0, 0};
   bit act [2];
   int st_e [2];
   int m_err [2];
   bit m_flag [2];
   int m_first [2];

   function automatic logic dref(int k, int lat);
      int j;
      j = k - lat;
      if (j >= r_edge && j >= 0) return dh[j];
      return 1'b0;
   endfunction

   function automatic logic [26:0] obs(int i);
      if (i == 0) return {busy0, done0, ef0, ec0, cc0, fe0};
      return {18'd0, busy1, done1, ef1, ec1, cc1, fe1};
   endfunction

   // Expected outputs from where the last edge sits on the current run's timeline.
   function automatic logic [26:0] exp_pack(int i);
      int rel, c;
      logic b, dn;
      b = 1'b0; dn = 1'b0; c = 0;
      if (act[i]) begin
         rel = edge_n - st_e[i];
         b   = (rel < latm[i] + winm[i]);
         dn  = !b;
         c   = rel - latm[i];
         if (c < 0) c = 0;
         if (c > winm[i]) c = winm[i];
      end
      if (i == 0) return {b, dn, m_flag[0], 8'(m_err[0]), 8'(c), 8'(m_first[0])};
      return {18'd0, b, dn, m_flag[1], 2'(m_err[1]), 2'(c), 2'(m_first[1])};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         act[i] = 1'b0; m_err[i] = 0; m_flag[i] = 1'b0; m_first[i] = maxm[i]; st_e[i] = 0;
      end
   endtask

   task automatic step(input logic dv, input logic st);
      int k;
      logic rv [2];
      logic qv [2];
      logic qbv [2];
      k = edge_n + 1;
      for (int i = 0; i < 2; i++) begin
         int idx;
         rv[i] = dref(k, latm[i]);
         idx = act[i] ? (k - st_e[i] - latm[i] - 1) : -1;
         qv[i] = rv[i]; qbv[i] = ~rv[i];
         case (mode[i])
            1: begin qv[i] = 1'b0; qbv[i] = 1'b1; end
            2: qbv[i] = rv[i];
            3: if (idx == inj[i]) qv[i] = ~rv[i];
            4: begin
               if ($urandom_range(0, 3) == 0) qv[i] = ~rv[i];
               if ($urandom_range(0, 5) == 0) qbv[i] = qv[i];
            end
            5: begin qv[i] = ~rv[i]; qbv[i] = ~rv[i]; end
            default: ;
         endcase
      end
      d = dv; start = st;
      q0 = qv[0]; qb0 = qbv[0]; q1 = qv[1]; qb1 = qbv[1];
      @(posedge clk);
      edge_n = k;
      dh[k] = dv;
      for (int i = 0; i < 2; i++) begin
         if (st) begin
            act[i] = 1'b1; st_e[i] = k; m_err[i] = 0; m_flag[i] = 1'b0; m_first[i] = maxm[i];
         end else if (act[i]) begin
            int rel;
            rel = k - st_e[i];
            if (rel >= latm[i] + 1 && rel <= latm[i] + winm[i]) begin
               if (qv[i] != rv[i] || qbv[i] == qv[i]) begin
                  if (!m_flag[i]) m_first[i] = rel - latm[i] - 1;
                  m_flag[i] = 1'b1;
                  if (m_err[i] < maxm[i]) m_err[i]++;
               end
            end
         end
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      model_clear();
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({busy0, done0, ef0, ec0, cc0, fe0} !== {3'b000, 8'd0, 8'd0, 8'hFF}) begin
         n_fail++; $display("FAIL reset_big got=%h exp=%h", {busy0, done0, ef0, ec0, cc0, fe0}, {3'b000, 8'd0, 8'd0, 8'hFF});
      end
      n_cmp++;
      if ({busy1, done1, ef1, ec1, cc1, fe1} !== {3'b000, 2'd0, 2'd0, 2'b11}) begin
         n_fail++; $display("FAIL reset_small got=%h exp=%h", {busy1, done1, ef1, ec1, cc1, fe1}, {3'b000, 2'd0, 2'd0, 2'b11});
      end
      @(posedge clk); edge_n++;
      @(negedge clk); rst = 1'b0; r_edge = edge_n + 1;
      for (int n = 0; n < 3; n++) begin
         step(1'($urandom_range(0, 1)), 1'b0);
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs(i) !== exp_pack(i)) begin
               n_fail++; $display("FAIL reset_idle inst%0d edge %0d got=%h exp=%h", i, edge_n, obs(i), exp_pack(i));
            end
         end
      end
   endtask

   task automatic test_pattern(input int m, input logic [15:0] pat, input int e_err, input int e_first);
      mode[0] = m; mode[1] = 0;
      step(1'b0, 1'b1);
      for (int n = 0; n < 17; n++) begin
         step((n < 16) ? pat[15-n] : 1'b0, 1'b0);
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs(i) !== exp_pack(i)) begin
               n_fail++; $display("FAIL pattern_m%0d inst%0d edge %0d got=%h exp=%h", m, i, edge_n, obs(i), exp_pack(i));
            end
         end
      end
      n_cmp++;
      if ({done0, busy0, ef0, ec0, cc0, fe0} !== {1'b1, 1'b0, (e_err != 0), 8'(e_err), 8'd16, 8'(e_first)}) begin
         n_fail++; $display("FAIL pattern_final_m%0d got done=%b err=%0d chk=%0d first=%h exp err=%0d first=%h",
                            m, done0, ec0, cc0, fe0, e_err, e_first);
      end
   endtask

   task automatic test_inject();
      mode[0] = 3; inj[0] = 5; mode[1] = 4;
      for (int run = 0; run < 2; run++) begin
         step(1'($urandom_range(0, 1)), 1'b1);
         for (int n = 0; n < 17; n++) begin
            step(1'($urandom_range(0, 1)), 1'b0);
            for (int i = 0; i < 2; i++) begin
               n_cmp++;
               if (obs(i) !== exp_pack(i)) begin
                  n_fail++; $display("FAIL inject inst%0d edge %0d got=%h exp=%h", i, edge_n, obs(i), exp_pack(i));
               end
            end
         end
         n_cmp++;
         if (run == 0 && {done0, ec0, fe0} !== {1'b1, 8'd1, 8'd5}) begin
            n_fail++; $display("FAIL inject_single got done=%b err=%0d first=%0d exp 1/1/5", done0, ec0, fe0);
         end else if (run == 1 && {done0, ef0, ec0, fe0} !== {1'b1, 1'b0, 8'd0, 8'hFF}) begin
            n_fail++; $display("FAIL inject_rerun got done=%b err=%0d first=%h exp 1/0/ff", done0, ec0, fe0);
         end
         mode[0] = 0;
      end
   endtask

   task automatic test_back_to_back();
      mode[0] = 4; mode[1] = 4;
      step(1'($urandom_range(0, 1)), 1'b1);
      for (int n = 0; n < 8; n++) step(1'($urandom_range(0, 1)), 1'b0);
      step(1'($urandom_range(0, 1)), 1'b1);
      n_cmp++;
      if ({busy0, done0, cc0} !== {1'b1, 1'b0, 8'd0}) begin
         n_fail++; $display("FAIL restart_at_7 got busy=%b done=%b chk=%0d exp 1/0/0", busy0, done0, cc0);
      end
      for (int seg = 0; seg < 2; seg++) begin
         for (int n = 0; n < 16; n++) begin
            step(1'($urandom_range(0, 1)), 1'b0);
            for (int i = 0; i < 2; i++) begin
               n_cmp++;
               if (obs(i) !== exp_pack(i)) begin
                  n_fail++; $display("FAIL back_to_back inst%0d edge %0d got=%h exp=%h", i, edge_n, obs(i), exp_pack(i));
               end
            end
         end
         n_cmp++;
         if ({busy0, done0, cc0} !== {1'b1, 1'b0, 8'd15}) begin
            n_fail++; $display("FAIL restart_not_done_yet got busy=%b done=%b chk=%0d exp 1/0/15", busy0, done0, cc0);
         end
         // seg 0: let the last check complete; seg 1: start lands on the final check
         step(1'($urandom_range(0, 1)), (seg == 1));
         n_cmp++;
         if (seg == 0 && {busy0, done0, cc0} !== {1'b0, 1'b1, 8'd16}) begin
            n_fail++; $display("FAIL restart_done got busy=%b done=%b chk=%0d exp 0/1/16", busy0, done0, cc0);
         end else if (seg == 1 && {busy0, done0, cc0, ec0} !== {1'b1, 1'b0, 8'd0, 8'd0}) begin
            n_fail++; $display("FAIL start_on_final got busy=%b done=%b chk=%0d err=%0d exp 1/0/0/0", busy0, done0, cc0, ec0);
         end
         if (seg == 0) step(1'($urandom_range(0, 1)), 1'b1);
      end
   endtask

   task automatic test_random();
      mode[0] = 4; mode[1] = 4;
      for (int n = 0; n < 400; n++) begin
         if (n % 50 == 0) begin
            mode[0] = $urandom_range(0, 5); mode[1] = $urandom_range(0, 5);
            inj[0] = $urandom_range(0, 15); inj[1] = $urandom_range(0, 2);
         end
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0));
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs(i) !== exp_pack(i)) begin
               n_fail++; $display("FAIL random inst%0d edge %0d got=%h exp=%h", i, edge_n, obs(i), exp_pack(i));
            end
         end
      end
   endtask

   task automatic test_small();
      for (int run = 0; run < 2; run++) begin
         mode[0] = 0; mode[1] = (run == 0) ? 1 : 5;
         step(1'b1, 1'b1);
         for (int n = 0; n < 6; n++) begin
            step(1'b1, 1'b0);
            n_cmp++;
            if (obs(1) !== exp_pack(1)) begin
               n_fail++; $display("FAIL small_sat edge %0d got=%h exp=%h", edge_n, obs(1), exp_pack(1));
            end
         end
         n_cmp++;
         if ({done1, ef1, ec1, cc1, fe1} !== {1'b1, 1'b1, 2'd3, 2'd3, 2'd0}) begin
            n_fail++; $display("FAIL small_final_%0d got done=%b err=%0d chk=%0d first=%0d exp 1/3/3/0", run, done1, ec1, cc1, fe1);
         end
      end
      mode[1] = 4;
      step(1'($urandom_range(0, 1)), 1'b1);
      for (int n = 0; n < 4; n++) step(1'($urandom_range(0, 1)), 1'b0);
      #2 rst = 1'b1;
      #1;
      model_clear();
      n_cmp++;
      if ({busy0, done0, ef0, ec0, cc0, fe0, busy1, done1, ef1, ec1, cc1, fe1} !==
          {3'b000, 8'd0, 8'd0, 8'hFF, 3'b000, 2'd0, 2'd0, 2'b11}) begin
         n_fail++; $display("FAIL mid_run_reset got big=%h small=%h", {busy0, done0, ef0, ec0, cc0, fe0}, {busy1, done1, ef1, ec1, cc1, fe1});
      end
      @(posedge clk); edge_n++;
      @(negedge clk); rst = 1'b0; r_edge = edge_n + 1;
      mode[0] = 0; mode[1] = 0;
      step(1'($urandom_range(0, 1)), 1'b1);
      for (int n = 0; n < 17; n++) begin
         step(1'($urandom_range(0, 1)), 1'b0);
         for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs(i) !== exp_pack(i)) begin
               n_fail++; $display("FAIL after_reset inst%0d edge %0d got=%h exp=%h", i, edge_n, obs(i), exp_pack(i));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_pattern(0, 16'b0101_1100_1010_0011, 0, 255);
      test_pattern(1, 16'b0101_1100_1010_0011, 8, 1);
      test_pattern(2, 16'h0000, 16, 0);
      test_inject();
      test_back_to_back();
      test_random();
      test_small();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached at edge %0d", edge_n);
      $fatal(1, "timeout");
   end

endmodule
